// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if
//   Groups the decode, execute, extender and front-end signals of the
//   branch sequencer into one bundle.
//
//   master : environment side (decode/execute/extender drive, front end reads)
//   slave  : branch_sequencer side
//
//   Signals
//     stall, instr_valid, branch, jump, instr_pc, offset, cond_true  -> sequencer
//     ext_data                                                       -> sequencer
//     ext_offset, ext_jump                                           <- sequencer (to extender)
//     pc, fetch_en, flush                                            <- sequencer (to front end)
//     branch_count, taken_count                                      <- sequencer (debug)

interface branch_sequencer_if #(
    parameter int ADDR_WIDTH       = 16,
    parameter int OFFSET_MAX_WIDTH = 12,
    parameter int CNT_WIDTH        = 8
);

    logic                        stall;
    logic                        instr_valid;
    logic                        branch;
    logic                        jump;
    logic [ADDR_WIDTH-1:0]       instr_pc;
    logic [OFFSET_MAX_WIDTH-1:0] offset;
    logic                        cond_true;
    logic [ADDR_WIDTH-1:0]       ext_data;

    logic [OFFSET_MAX_WIDTH-1:0] ext_offset;
    logic                        ext_jump;
    logic [ADDR_WIDTH-1:0]       pc;
    logic                        fetch_en;
    logic                        flush;
    logic [CNT_WIDTH-1:0]        branch_count;
    logic [CNT_WIDTH-1:0]        taken_count;

    modport master (
        output stall,
        output instr_valid,
        output branch,
        output jump,
        output instr_pc,
        output offset,
        output cond_true,
        output ext_data,
        input  ext_offset,
        input  ext_jump,
        input  pc,
        input  fetch_en,
        input  flush,
        input  branch_count,
        input  taken_count
    );

    modport slave (
        input  stall,
        input  instr_valid,
        input  branch,
        input  jump,
        input  instr_pc,
        input  offset,
        input  cond_true,
        input  ext_data,
        output ext_offset,
        output ext_jump,
        output pc,
        output fetch_en,
        output flush,
        output branch_count,
        output taken_count
    );

endinterface

// File: rtl/branch_sequencer.sv
// branch_sequencer
//   Owns the program counter of the 16-bit core and sequences PC-relative
//   control flow through the external sign-extend/shift unit. A branch or
//   jump accepted in RUN latches its offset and width select toward the
//   extender, then spends one RESOLVE cycle adding the extender result to
//   the instruction PC and, if taken, redirecting the PC with a flush pulse.
//   Saturating counters record resolved and taken control transfers.
//
//   Ports
//     clk  : system clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : branch_sequencer_if.slave
//            decode/execute inputs, extender handshake, front-end pc,
//            fetch_en, flush and the two debug counters

module branch_sequencer #(
    parameter int ADDR_WIDTH       = 16,
    parameter int OFFSET_MAX_WIDTH = 12,
    parameter int OFFSET_MIN_WIDTH = 8,
    parameter int PC_INC           = 2,
    parameter int RESET_PC         = 0,
    parameter int CNT_WIDTH        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_sequencer_if.slave    bus
);

    // The extender narrows to the branch field and widens to ADDR_WIDTH,
    // so the field widths must nest inside the address width.
    if (OFFSET_MIN_WIDTH > OFFSET_MAX_WIDTH || OFFSET_MAX_WIDTH >= ADDR_WIDTH) begin : g_bad_widths
        $error("branch_sequencer: offset widths must satisfy MIN <= MAX < ADDR_WIDTH");
    end

    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(PC_INC);
    localparam logic [ADDR_WIDTH-1:0] PC_RESET = ADDR_WIDTH'(RESET_PC);

    typedef enum logic {
        RUN,
        RESOLVE
    } state_t;

    state_t                      state_q, state_d;
    logic [ADDR_WIDTH-1:0]       pc_q, pc_d;
    logic [OFFSET_MAX_WIDTH-1:0] ext_offset_q, ext_offset_d;
    logic                        ext_jump_q, ext_jump_d;
    logic [ADDR_WIDTH-1:0]       base_q, base_d;
    logic                        kind_q, kind_d;
    logic [CNT_WIDTH-1:0]        branch_count_q, branch_count_d;
    logic [CNT_WIDTH-1:0]        taken_count_q, taken_count_d;

    logic                        fetch_en;
    logic                        flush;
    logic                        taken;
    logic [ADDR_WIDTH-1:0]       target;
    logic                        accept;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Redirect target wraps modulo 2^ADDR_WIDTH; jumps are always taken.
    assign target = base_q + bus.ext_data;
    assign taken  = kind_q | bus.cond_true;
    assign accept = bus.instr_valid & (bus.branch | bus.jump);

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ext_offset_d   = ext_offset_q;
        ext_jump_d     = ext_jump_q;
        base_d         = base_q;
        kind_d         = kind_q;
        branch_count_d = branch_count_q;
        taken_count_d  = taken_count_q;
        fetch_en       = 1'b0;
        flush          = 1'b0;

        unique case (state_q)
            RUN: begin
                fetch_en = !bus.stall;
                if (!bus.stall) begin
                    pc_d = pc_q + PC_STEP;
                    if (accept) begin
                        // jump alone selects the wide field, so jump wins over branch
                        ext_offset_d = bus.offset;
                        ext_jump_d   = bus.jump;
                        base_d       = bus.instr_pc;
                        kind_d       = bus.jump;
                        state_d      = RESOLVE;
                    end
                end
            end

            RESOLVE: begin
                if (!bus.stall) begin
                    branch_count_d = sat_inc(branch_count_q);
                    if (taken) begin
                        flush         = 1'b1;
                        pc_d          = target;
                        taken_count_d = sat_inc(taken_count_q);
                    end
                    state_d = RUN;
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase

        // Reset overrides the combinational outputs in the same cycle it is
        // asserted, so a RESOLVE interrupted by reset never flushes.
        if (rst) begin
            fetch_en = 1'b0;
            flush    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            pc_q           <= PC_RESET;
            ext_offset_q   <= '0;
            ext_jump_q     <= 1'b0;
            base_q         <= '0;
            kind_q         <= 1'b0;
            branch_count_q <= '0;
            taken_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            ext_offset_q   <= ext_offset_d;
            ext_jump_q     <= ext_jump_d;
            base_q         <= base_d;
            kind_q         <= kind_d;
            branch_count_q <= branch_count_d;
            taken_count_q  <= taken_count_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.ext_offset   = ext_offset_q;
    assign bus.ext_jump     = ext_jump_q;
    assign bus.fetch_en     = fetch_en;
    assign bus.flush        = flush;
    assign bus.branch_count = branch_count_q;
    assign bus.taken_count  = taken_count_q;

endmodule
